mdu_hilo: RTL and testbench

Parametrised multiply/divide unit owning the architectural HI/LO register pair. It sits beside the EX-stage ALU and replaces the vendor divider cores and the stand-alone HI/LO register file. It adds an in-house iterative divider, multiply-accumulate ops, defined divide-by-zero results, and exception-flush cancellation of in-flight operations. The hazard unit stalls EX on `busy` and on HI/LO reads while an operation is pending.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/div_iter.sv | 58 +++++
 rtl/mdu_hilo.sv | 180 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, op-class helpers.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // MULT/MULTU and the MADD/MSUB family all use the multiplier
  function automatic logic op_is_mul(input logic [3:0] op);
    return (op[3:1] == 3'b000) || (op[3:2] == 2'b01);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op[3:1] == 3'b001;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle, XLEN cycles after start.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    shifted;
  logic [XLEN-1:0]  diff;
  logic             fits;

  // Partial remainder shifted by one with the next dividend bit; a fitting trial always leaves < divisor
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, dvs_q};
    diff    = shifted[XLEN-1:0] - dvs_q;
  end

  assign last_c    = run_q && (cnt_q == CNT_W'(XLEN - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= fits ? diff : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      if (last_c) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning HI/LO: pipelined multiplier, MADD/MSUB accumulate, iterative divide, flush cancel.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned PW = 2 * XLEN;

  mdu_state_e      state_q, state_d;
  logic            accept;
  logic [2:0]      op_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [1:0]      mul_cnt_q;
  logic            mul_last;
  logic            mul_signed;
  logic [PW-1:0]   mul_a, mul_b, prod_c, prod_d, acc_c;
  logic            div_start, req_div_signed;
  logic [XLEN-1:0] mag1, mag2, div_q_raw, div_r_raw;
  logic            div_last_c;
  logic            div_signed, s1, s2;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            hilo_we;
  logic [XLEN-1:0] hi_d, lo_d;

  assign accept    = req_valid && (state_q == ST_IDLE) && !flush;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= req_op[2:0];
      src1_q <= req_src1;
      src2_q <= req_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  mul_cnt_q <= '0;
    else if (accept)            mul_cnt_q <= '0;
    else if (state_q == ST_MUL) mul_cnt_q <= mul_cnt_q + 2'd1;
  end

  assign mul_last = (mul_cnt_q == 2'(MUL_LAT - 1));

  // Operands sign- or zero-extended to 2*XLEN so a plain modular multiply yields the exact product
  assign mul_signed = !op_q[0];
  assign mul_a  = {{XLEN{mul_signed & src1_q[XLEN-1]}}, src1_q};
  assign mul_b  = {{XLEN{mul_signed & src2_q[XLEN-1]}}, src2_q};
  assign prod_c = mul_a * mul_b;

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign prod_d = prod_c;
    end else begin : g_mul_pipe
      logic [PW-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk) begin
        pipe_q[0] <= prod_c;
        for (int unsigned i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign prod_d = pipe_q[MUL_LAT-2];
    end
  endgenerate

  // MADD/MSUB fold into whatever HI/LO holds at the commit edge
  always_comb begin
    acc_c = prod_d;
    if (op_q[2]) acc_c = op_q[1] ? ({hi, lo} - prod_d) : ({hi, lo} + prod_d);
  end

  assign req_div_signed = (req_op == OP_DIV);
  assign div_start      = accept && op_is_div(req_op);
  assign mag1 = (req_div_signed && req_src1[XLEN-1]) ? -req_src1 : req_src1;
  assign mag2 = (req_div_signed && req_src2[XLEN-1]) ? -req_src2 : req_src2;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_q_raw),
    .remainder (div_r_raw),
    .last_c    (div_last_c)
  );

  // Sign fix-up; MIN/-1 falls out naturally since -MIN wraps back to MIN
  assign div_signed = !op_q[0];
  assign s1 = div_signed && src1_q[XLEN-1];
  assign s2 = div_signed && src2_q[XLEN-1];

  always_comb begin
    quo_fix = (s1 ^ s2) ? -div_q_raw : div_q_raw;
    rem_fix = s1 ? -div_r_raw : div_r_raw;
    if (src2_q == '0) begin
      quo_fix = '1;
      rem_fix = src1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hilo_we = 1'b0;
    hi_d    = hi;
    lo_d    = lo;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_mul(req_op))      state_d = ST_MUL;
          else if (op_is_div(req_op)) state_d = ST_DIV;
          else begin
            state_d = ST_DONE;
            if (req_op == OP_MTHI) begin
              hilo_we = 1'b1;
              hi_d    = req_src1;
            end
            if (req_op == OP_MTLO) begin
              hilo_we = 1'b1;
              lo_d    = req_src1;
            end
          end
        end
      end
      ST_MUL: begin
        if (flush) state_d = ST_IDLE;
        else if (mul_last) begin
          state_d      = ST_DONE;
          hilo_we      = 1'b1;
          {hi_d, lo_d} = acc_c;
        end
      end
      ST_DIV: begin
        if (flush)           state_d = ST_IDLE;
        else if (div_last_c) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (flush) state_d = ST_IDLE;
        else begin
          state_d = ST_DONE;
          hilo_we = 1'b1;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (hilo_we) begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases, randomized ops against an arithmetic model, flush and reset.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_hi = 32'd0, mdl_lo = 32'd0;

  mdu_hilo #(.XLEN(32), .MUL_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one committed op on {HI,LO}
  function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] acc, ps, pu;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    acc = {mdl_hi, mdl_lo};
    ps = sa * sb;
    pu = ua * ub;
    case (op)
      4'd0: {mdl_hi, mdl_lo} = ps;
      4'd1: {mdl_hi, mdl_lo} = pu;
      4'd4: {mdl_hi, mdl_lo} = acc + ps;
      4'd5: {mdl_hi, mdl_lo} = acc + pu;
      4'd6: {mdl_hi, mdl_lo} = acc - ps;
      4'd7: {mdl_hi, mdl_lo} = acc - pu;
      4'd2, 4'd3: begin
        if (b == 32'd0) begin
          mdl_lo = 32'hFFFFFFFF; mdl_hi = a;
        end else if (op == 4'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          mdl_lo = 32'h80000000; mdl_hi = 32'd0;
        end else if (op == 4'd2) begin
          mdl_lo = ia / ib; mdl_hi = ia % ib;
        end else begin
          mdl_lo = a / b; mdl_hi = a % b;
        end
      end
      4'd8: mdl_hi = a;
      4'd9: mdl_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd2 || op == 4'd3) return 34;
    if (op <= 4'd7) return 2;
    return 1;
  endfunction

  // Issue one op when ready; returns cycles from accept to done (100 means no done seen)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin step(); guard++; end
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin step(); lat++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; req_op = 4'd0; req_src1 = '0; req_src2 = '0;
    repeat (3) step();
    reset = 1'b0;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_mul_directed();
    int lat;
    run_op(4'd0, 32'hFFFFFFFE, 32'd3, lat); model_apply(4'd0, 32'hFFFFFFFE, 32'd3);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mult_lat: got %0d expected 2", lat); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mult_hilo: got %h_%h expected ffffffff_fffffffa", hi, lo); end
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, lat); model_apply(4'd1, 32'hFFFFFFFE, 32'd3);
    checks++; if ({hi, lo} !== 64'h00000002_FFFFFFFA) begin errors++; $display("FAIL multu_hilo: got %h_%h expected 00000002_fffffffa", hi, lo); end
  endtask

  task automatic test_div_directed();
    int lat;
    run_op(4'd2, 32'hFFFFFFF9, 32'd2, lat); model_apply(4'd2, 32'hFFFFFFF9, 32'd2);
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_lat: got %0d expected 34", lat); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg7_2: got %h_%h expected ffffffff_fffffffd", hi, lo); end
    run_op(4'd3, 32'd7, 32'd2, lat); model_apply(4'd3, 32'd7, 32'd2);
    checks++; if ({hi, lo} !== 64'h00000001_00000003) begin errors++; $display("FAIL divu_7_2: got %h_%h expected 00000001_00000003", hi, lo); end
    run_op(4'd3, 32'd7, 32'd0, lat); model_apply(4'd3, 32'd7, 32'd0);
    checks++; if ({hi, lo} !== 64'h00000007_FFFFFFFF) begin errors++; $display("FAIL divu_by0: got %h_%h expected 00000007_ffffffff", hi, lo); end
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, lat); model_apply(4'd2, 32'h80000000, 32'hFFFFFFFF);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_min_m1: got %h_%h expected 00000000_80000000", hi, lo); end
  endtask

  task automatic test_accumulate();
    int lat;
    run_op(4'd8, 32'd0, 32'd0, lat); model_apply(4'd8, 32'd0, 32'd0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mthi_lat: got %0d expected 1", lat); end
    run_op(4'd9, 32'hFFFFFFFF, 32'd0, lat); model_apply(4'd9, 32'hFFFFFFFF, 32'd0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mtlo_lat: got %0d expected 1", lat); end
    run_op(4'd5, 32'd1, 32'd1, lat); model_apply(4'd5, 32'd1, 32'd1);
    checks++; if ({hi, lo} !== 64'h00000001_00000000) begin errors++; $display("FAIL maddu: got %h_%h expected 00000001_00000000", hi, lo); end
    run_op(4'd7, 32'd1, 32'd1, lat); model_apply(4'd7, 32'd1, 32'd1);
    checks++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL msubu: got %h_%h expected 00000000_ffffffff", hi, lo); end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, lat);
      model_apply(op, a, b);
      checks++; if (lat !== exp_lat(op)) begin errors++; $display("FAIL rand_lat op%0d: got %0d expected %0d", op, lat, exp_lat(op)); end
      checks++; if (hi !== mdl_hi) begin errors++; $display("FAIL rand_hi op%0d a=%h b=%h: got %h expected %h", op, a, b, hi, mdl_hi); end
      checks++; if (lo !== mdl_lo) begin errors++; $display("FAIL rand_lo op%0d a=%h b=%h: got %h expected %h", op, a, b, lo, mdl_lo); end
    end
  endtask

  // Start a DIV, flush in the given busy cycle (1 = first DIV cycle, 33 = FIX)
  task automatic flush_div_at(input int cyc, input string tag);
    int lat;
    bit seen_done;
    run_op(4'd8, 32'h1234_5678, 32'd0, lat); model_apply(4'd8, 32'h1234_5678, 32'd0);
    run_op(4'd9, 32'h9ABC_DEF0, 32'd0, lat); model_apply(4'd9, 32'h9ABC_DEF0, 32'd0);
    step();
    req_valid = 1'b1; req_op = 4'd3; req_src1 = 32'd100; req_src2 = 32'd7;
    step();
    req_valid = 1'b0;
    seen_done = done;
    for (int c = 1; c < cyc; c++) begin step(); seen_done |= done; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", tag, busy); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen_done |= done;
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b expected 0", tag, seen_done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", tag, req_ready); end
    checks++; if ({hi, lo} !== {mdl_hi, mdl_lo}) begin errors++; $display("FAIL %s_hilo: got %h_%h expected %h_%h", tag, hi, lo, mdl_hi, mdl_lo); end
  endtask

  task automatic test_flush();
    int lat;
    flush_div_at(10, "flush_div10");
    flush_div_at(33, "flush_fix");
    // Flush together with a request in IDLE must block acceptance
    req_valid = 1'b1; req_op = 4'd8; req_src1 = 32'hDEAD_BEEF; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b expected 1", req_ready); end
    checks++; if (hi !== mdl_hi) begin errors++; $display("FAIL flush_idle_hi: got %h expected %h", hi, mdl_hi); end
    // Flush on the final MUL cycle cancels the commit
    req_valid = 1'b1; req_op = 4'd0; req_src1 = 32'd5; req_src2 = 32'd6;
    step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if ({done, hi, lo} !== {1'b0, mdl_hi, mdl_lo}) begin errors++; $display("FAIL flush_mul: got %b %h_%h expected 0 %h_%h", done, hi, lo, mdl_hi, mdl_lo); end
    // Flush in DONE leaves the committed value in place
    run_op(4'd8, 32'h0BAD_F00D, 32'd0, lat); model_apply(4'd8, 32'h0BAD_F00D, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_done_hi: got %h expected 0badf00d", hi); end
  endtask

  task automatic test_back_to_back();
    step();
    req_valid = 1'b1; req_op = 4'd8; req_src1 = 32'hAAAA_0001;
    step();
    checks++; if ({req_ready, done, hi} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin errors++; $display("FAIL b2b_first: got %b %b %h expected 0 1 aaaa0001", req_ready, done, hi); end
    req_src1 = 32'hBBBB_0002;
    step();
    checks++; if ({req_ready, done, hi} !== {1'b1, 1'b0, 32'hAAAA_0001}) begin errors++; $display("FAIL b2b_idle: got %b %b %h expected 1 0 aaaa0001", req_ready, done, hi); end
    step();
    req_valid = 1'b0;
    model_apply(4'd8, 32'hBBBB_0002, 32'd0);
    checks++; if ({req_ready, done, hi} !== {1'b0, 1'b1, 32'hBBBB_0002}) begin errors++; $display("FAIL b2b_second: got %b %b %h expected 0 1 bbbb0002", req_ready, done, hi); end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    logic [31:0] a, b;
    run_op(4'd8, 32'h1111_2222, 32'd0, lat);
    run_op(4'd9, 32'h3333_4444, 32'd0, lat);
    step();
    req_valid = 1'b1; req_op = 4'd2; req_src1 = 32'd1000; req_src2 = 32'd3;
    step();
    req_valid = 1'b0;
    repeat (14) step();
    reset = 1'b1;
    step();
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h_%h expected 0_0", hi, lo); end
    checks++; if ({busy, req_ready, done} !== 3'b010) begin errors++; $display("FAIL rst_mid_ctrl: got %b expected 010", {busy, req_ready, done}); end
    reset = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    a = $urandom; b = $urandom_range(1, 50000);
    run_op(4'd2, a, b, lat); model_apply(4'd2, a, b);
    checks++; if ({lat, hi, lo} !== {34, mdl_hi, mdl_lo}) begin errors++; $display("FAIL rst_mid_div: got %0d %h_%h expected 34 %h_%h", lat, hi, lo, mdl_hi, mdl_lo); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_accumulate();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
